// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_skid_reg : two-entry (main + skid) elastic register, valid/ready both |
// | sides, full throughput, InReady taken straight from a flop.                |
// | Optional Flush port when PIPE_SKID_FLUSH_EN is defined.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic             Flush,
`endif
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData
);

   // bit0 = main entry valid, bit1 = skid entry valid
   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] ONE   = 2'b01;
   localparam logic [1:0] FULL  = 2'b11;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             in_ready_reg;
   logic [WIDTH-1:0] main_reg;
   logic [WIDTH-1:0] skid_reg;
   logic [WIDTH-1:0] main_next;
   logic             main_load;
   logic             skid_load;
   logic             in_xfer;
   logic             out_xfer;
   logic             flush_req;

`ifdef PIPE_SKID_FLUSH_EN
   assign flush_req = Flush;
`else
   assign flush_req = 1'b0;
`endif

   assign in_xfer  = InValid & in_ready_reg;
   assign out_xfer = state[0] & OutReady;

   always_comb begin
      state_next = state;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_next  = InData;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               state_next = ONE;
               main_load  = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_load = 1'b1;
            end else if (in_xfer) begin
               state_next = FULL;
               skid_load  = 1'b1;
            end else if (out_xfer) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_next = ONE;
               main_load  = 1'b1;
               main_next  = skid_reg;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flush overrides any handshake; data registers keep their contents.
      if (flush_req) begin
         state_next = EMPTY;
         main_load  = 1'b0;
         skid_load  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         state        <= state_next;
         in_ready_reg <= (state_next != FULL);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_reg <= '0;
         skid_reg <= '0;
      end else begin
         if (main_load) main_reg <= main_next;
         if (skid_load) skid_reg <= InData;
      end
   end

   assign InReady  = in_ready_reg;
   assign OutValid = state[0];
   assign OutData  = main_reg;

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register with a valid/ready handshake on both sides.
- A plain enable flop is the write end, where upstream loads when enabled. This block also owns the read end: downstream pulls data with OutReady, and upstream sees backpressure through InReady.
- A two-entry skid structure (main + skid) gives full throughput, 1 beat/cycle, with InReady driven from a register only.
- Used between Wally pipeline stages or bus adapters where stall timing must not be combinationally coupled.

Parameters:
- WIDTH, 8, payload width in bits.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- InValid  input  1  upstream beat valid.
- InReady  output  1  block can accept a beat; driven directly from a flop.
- InData  input  WIDTH  upstream payload.
- OutValid  output  1  beat available downstream.
- OutReady  input  1  downstream accepts the beat.
- OutData  output  WIDTH  downstream payload; comes from the main register.
- Flush  input  1  drop all held beats; present only with PIPE_SKID_FLUSH_EN.

Behaviour:
- Handshakes:
  - Input transfer (InXfer) = InValid & InReady.
  - Output transfer (OutXfer) = OutValid & OutReady.
  - Both evaluated at the posedge.
- State:
  - Storage: MainReg/MainValid and SkidReg/SkidValid.
  - OutValid = MainValid; OutData = MainReg; InReady = ~SkidValid.
  - States: EMPTY (MainValid=0, SkidValid=0), ONE (1,0), FULL (1,1). SkidValid=1 with MainValid=0 is illegal and unreachable.
- Transitions:
  - EMPTY, InXfer -> ONE; MainReg <= InData.
  - ONE, InXfer & OutXfer -> ONE; MainReg <= InData (pass-through, no bubble).
  - ONE, InXfer & ~OutXfer -> FULL; SkidReg <= InData; MainReg unchanged.
  - ONE, ~InXfer & OutXfer -> EMPTY.
  - FULL, OutXfer -> ONE; MainReg <= SkidReg. InReady is 0 in FULL, so InXfer cannot occur.
  - No handshake -> hold all state.
- Latency: a beat accepted at edge N is presented on OutData/OutValid after edge N (1 cycle).
- Stability: while OutValid=1 and OutReady=0, OutData and OutValid hold constant.
- Ordering: strict FIFO; no beat is dropped or duplicated except by Flush.
- Reset (asynchronous, active-high):
  - MainValid=0, SkidValid=0, so OutValid=0 and InReady=1.
  - MainReg and SkidReg are cleared to 0.
  - A reset asserted mid-transfer discards both entries immediately, without waiting for a clock edge.
  - On deassertion, the block is in EMPTY.
- Inputs outside handshake: InData is ignored when InValid=0. OutReady is ignored when OutValid=0.
- Combinational paths: none from OutReady to InReady, and none from InValid to OutValid.

Optional Feature:
- Macro: PIPE_SKID_FLUSH_EN.
- Defined:
  - Flush port exists.
  - Flush=1 at a posedge forces next state EMPTY (MainValid=0, SkidValid=0). Flush takes priority over any simultaneous InXfer/OutXfer. InReady=1 on the following cycle.
  - An OutXfer in the same cycle as Flush is still counted as completed by downstream. A beat offered at InXfer in that cycle is dropped.
  - Data registers are not cleared by Flush.
- Undefined: Flush port is absent and state changes only via handshakes and reset.

Test Plan:
- Reset: assert reset asynchronously between edges while in FULL holding 0x11/0x22 -> OutValid=0 and InReady=1 before the next edge; after release, OutValid stays 0 with no input.
- Streaming: OutReady=1 constant, send 0x01..0x10 with InValid=1 every cycle -> OutData shows 0x01..0x10 on consecutive cycles, 1-cycle latency, InReady never drops.
- Backpressure: send 0xA1, 0xA2, 0xA3 with OutReady=0 -> state FULL after 0xA2, InReady=0, 0xA3 held off; OutData=0xA1 stable. Then OutReady=1 for 3 cycles -> outputs 0xA1, 0xA2, 0xA3 in order.
- Simultaneous: in ONE holding 0x55, InValid=1 with 0x66 and OutReady=1 on the same edge -> 0x55 consumed, OutData=0x66 next cycle, state remains ONE.
- Random: random InValid/OutReady at 50%, 1000 beats with an incrementing payload -> scoreboard shows no loss, duplication or reorder; OutData constant whenever OutValid&~OutReady.
- Flush (PIPE_SKID_FLUSH_EN only): in FULL with 0x77/0x88, Flush=1 with InValid=1 (0x99) -> next cycle OutValid=0, InReady=1; 0x77, 0x88 and 0x99 never appear.
